// File: rtl/echo_portal_multi_if.sv
// Host-side bus of the echo portal: per-channel request/indication
// handshakes, interrupt summary and message-size query.
interface echo_portal_multi_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32
);
    logic [NUM_CH*DATA_W-1:0] request_say_v;
    logic [NUM_CH-1:0]        EN_request_say;
    logic [NUM_CH-1:0]        RDY_request_say;
    logic [NUM_CH-1:0]        EN_indications_deq;
    logic [NUM_CH-1:0]        RDY_indications_deq;
    logic [NUM_CH-1:0]        indications_notEmpty;
    logic [NUM_CH*DATA_W-1:0] indications_first;
    logic                     intr_status;
    logic [31:0]              intr_channel;
    logic [15:0]              messageSize_size_methodNumber;
    logic [15:0]              messageSize_size;
    logic                     RDY_intr_status;
    logic                     RDY_intr_channel;
    logic                     RDY_messageSize_size;

    // Host side: drives strobes/payloads, observes readiness and data.
    modport master (
        output request_say_v, EN_request_say, EN_indications_deq,
               messageSize_size_methodNumber,
        input  RDY_request_say, RDY_indications_deq, indications_notEmpty,
               indications_first, intr_status, intr_channel, messageSize_size,
               RDY_intr_status, RDY_intr_channel, RDY_messageSize_size
    );

    // Portal side.
    modport slave (
        input  request_say_v, EN_request_say, EN_indications_deq,
               messageSize_size_methodNumber,
        output RDY_request_say, RDY_indications_deq, indications_notEmpty,
               indications_first, intr_status, intr_channel, messageSize_size,
               RDY_intr_status, RDY_intr_channel, RDY_messageSize_size
    );
endinterface

// File: rtl/echo_portal_multi.sv
// Multi-channel echo portal: every accepted request word is copied (optionally
// byte-reversed) into that channel's own indication FIFO. Channels never
// interact except through the interrupt summary.
module echo_portal_multi #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int SWAP   = 0
) (
    input  logic CLK,
    input  logic RST_N,
    echo_portal_multi_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [NUM_CH-1:0]        not_empty;
    logic [NUM_CH-1:0]        rdy_req;
    logic [NUM_CH*DATA_W-1:0] first_flat;
    logic [31:0]              intr_ch;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]  count_q, count_d;
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] din_sw;
        logic              full;
        logic              wr_en;
        logic              rd_en;

        assign din = bus.request_say_v[gi*DATA_W +: DATA_W];

        if (SWAP != 0) begin : g_swap
            for (genvar bi = 0; bi < DATA_W/8; bi++) begin : g_byte
                assign din_sw[bi*8 +: 8] = din[DATA_W-8-bi*8 +: 8];
            end
        end else begin : g_noswap
            assign din_sw = din;
        end

        assign full          = (count_q == CNT_W'(DEPTH));
        assign not_empty[gi] = (count_q != '0);
        // A pop in the same cycle frees a slot, so a full FIFO may still accept.
        assign rdy_req[gi]   = !full || bus.EN_indications_deq[gi];
        assign wr_en         = bus.EN_request_say[gi] && rdy_req[gi];
        // Pop only what was already stored; a same-cycle push into empty is not poppable.
        assign rd_en         = bus.EN_indications_deq[gi] && not_empty[gi];

        assign first_flat[gi*DATA_W +: DATA_W] =
            not_empty[gi] ? mem_q[rd_ptr_q] : '0;

        // Next pointers and occupancy; pointers wrap naturally at power-of-2 depth.
        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Pointer/count state, cleared immediately by reset.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        // Payload storage; contents need no reset since reads are gated by occupancy.
        always_ff @(posedge CLK) begin
            if (wr_en) mem_q[wr_ptr_q] <= din_sw;
        end
    end

    // Lowest-index non-empty channel wins; zero when nothing is pending.
    always_comb begin
        intr_ch = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (not_empty[k]) intr_ch = 32'(k);
        end
    end

    assign bus.RDY_request_say      = rdy_req;
    assign bus.RDY_indications_deq  = not_empty;
    assign bus.indications_notEmpty = not_empty;
    assign bus.indications_first    = first_flat;
    assign bus.intr_status          = |not_empty;
    assign bus.intr_channel         = intr_ch;
    assign bus.messageSize_size     =
        (bus.messageSize_size_methodNumber == 16'd0) ? 16'(DATA_W) : 16'd0;
    assign bus.RDY_intr_status      = RST_N;
    assign bus.RDY_intr_channel     = RST_N;
    assign bus.RDY_messageSize_size = RST_N;
endmodule
